// File: rtl/player_sprite_render_if.sv
// Pixel-stream bundle for player_sprite_render: scan position, background
// pixel, sprite position, sprite ROM address/data and the composited output.
// The master side drives the scan stream and answers ROM reads; the slave
// side is the renderer.
interface player_sprite_render_if #(
  parameter int ADDR_W = 9
);
  logic              frame_start;
  logic              pix_valid;
  logic [9:0]        hcount;
  logic [9:0]        vcount;
  logic [7:0]        bg_pixel;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [7:0]        pix_out;
  logic              pix_out_valid;
  logic              sprite_hit;

  modport master (
    output frame_start, pix_valid, hcount, vcount, bg_pixel, pos_x, pos_y, rom_q,
    input  rom_addr, pix_out, pix_out_valid, sprite_hit
  );

  modport slave (
    input  frame_start, pix_valid, hcount, vcount, bg_pixel, pos_x, pos_y, rom_q,
    output rom_addr, pix_out, pix_out_valid, sprite_hit
  );
endinterface

// File: rtl/player_sprite_render.sv
// Player sprite overlay stage sitting in front of a 1-cycle registered sprite
// ROM. Stage 1 registers the ROM address, stage 2 is the ROM's own register
// (side data delayed alongside it), stage 3 composites sprite over background.
// Sprite position is latched on frame_start only, so the sprite never tears.
// Optional feature macro: SPRITE_COLORKEY_EN (ROM words equal to KEY_COLOR
// become transparent).
module player_sprite_render #(
  parameter int          SPRITE_W  = 20,
  parameter int          SPRITE_H  = 20,
  parameter int          ADDR_W    = 9,
  parameter int          H_ACTIVE  = 640,
  parameter int          V_ACTIVE  = 480,
  parameter logic [7:0]  KEY_COLOR = 8'h00
) (
  input logic                     clock,
  input logic                     reset,
  player_sprite_render_if.slave   bus
);

  localparam int ROW_MAX = SPRITE_W * (SPRITE_H - 1);

  // Advance the row base by one sprite line, holding at the last row's base
  // so a stray extra line end can never wrap the address.
  function automatic logic [ADDR_W-1:0] row_step_sat(input logic [ADDR_W-1:0] base);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + (ADDR_W+1)'(SPRITE_W);
    if (sum > (ADDR_W+1)'(ROW_MAX)) return ADDR_W'(ROW_MAX);
    return sum[ADDR_W-1:0];
  endfunction

  logic [9:0]        lx_q, lx_d, ly_q, ly_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] rom_addr_p1_q, rom_addr_d;
  logic              in_box_p1_q, vld_p1_q;
  logic [7:0]        bg_p1_q;
  logic              in_box_p2_q, vld_p2_q;
  logic [7:0]        bg_p2_q;
  logic [7:0]        pix_p3_q, pix_d;
  logic              hit_p3_q, hit_d, vld_p3_q;

  logic [10:0] hc, vc, lx, ly;
  logic        in_h, in_v, in_box, row_end, opaque;
  logic [4:0]  col;

  // 11-bit compares so lx+SPRITE_W cannot wrap near the right/bottom edge;
  // the active-area bounds clip any part of the sprite beyond the screen.
  assign hc      = {1'b0, bus.hcount};
  assign vc      = {1'b0, bus.vcount};
  assign lx      = {1'b0, lx_q};
  assign ly      = {1'b0, ly_q};
  assign in_h    = (hc >= lx) && (hc < lx + 11'(SPRITE_W)) && (hc < 11'(H_ACTIVE));
  assign in_v    = (vc >= ly) && (vc < ly + 11'(SPRITE_H)) && (vc < 11'(V_ACTIVE));
  assign in_box  = bus.pix_valid && in_h && in_v;
  assign row_end = bus.pix_valid && (bus.hcount == 10'(H_ACTIVE - 1)) && in_v;
  // Column comes from hcount itself, so a horizontally clipped sprite still
  // addresses the correct ROM column.
  assign col     = bus.hcount[4:0] - lx_q[4:0];

`ifdef SPRITE_COLORKEY_EN
  assign opaque = (bus.rom_q != KEY_COLOR);
`else
  // Every sprite pixel is opaque; the key term folds to a constant so no
  // comparator survives synthesis.
  assign opaque = !(1'b0 && (bus.rom_q == KEY_COLOR));
`endif

  // Next state for the per-frame position latch, row base and ROM address.
  always_comb begin
    lx_d       = lx_q;
    ly_d       = ly_q;
    row_base_d = row_base_q;
    if (bus.frame_start) begin
      lx_d       = bus.pos_x;
      ly_d       = bus.pos_y;
      row_base_d = '0;
    end else if (row_end) begin
      row_base_d = row_step_sat(row_base_q);
    end
    rom_addr_d = in_box ? (row_base_q + ADDR_W'(col)) : '0;
  end

  // Stage 1: address register, position latch and row base.
  always_ff @(posedge clock) begin
    if (reset) begin
      lx_q          <= '0;
      ly_q          <= '0;
      row_base_q    <= '0;
      rom_addr_p1_q <= '0;
      in_box_p1_q   <= 1'b0;
      vld_p1_q      <= 1'b0;
      bg_p1_q       <= '0;
    end else begin
      lx_q          <= lx_d;
      ly_q          <= ly_d;
      row_base_q    <= row_base_d;
      rom_addr_p1_q <= rom_addr_d;
      in_box_p1_q   <= in_box;
      vld_p1_q      <= bus.pix_valid;
      bg_p1_q       <= bus.bg_pixel;
    end
  end

  // Stage 2: side data held for the cycle the ROM spends registering its word.
  always_ff @(posedge clock) begin
    if (reset) begin
      in_box_p2_q <= 1'b0;
      vld_p2_q    <= 1'b0;
      bg_p2_q     <= '0;
    end else begin
      in_box_p2_q <= in_box_p1_q;
      vld_p2_q    <= vld_p1_q;
      bg_p2_q     <= bg_p1_q;
    end
  end

  // Compose selection: blank outside the active area, sprite when opaque
  // and in-box, background otherwise.
  always_comb begin
    pix_d = '0;
    hit_d = 1'b0;
    if (vld_p2_q) begin
      if (in_box_p2_q && opaque) begin
        pix_d = bus.rom_q;
        hit_d = 1'b1;
      end else begin
        pix_d = bg_p2_q;
      end
    end
  end

  // Stage 3: compose register.
  always_ff @(posedge clock) begin
    if (reset) begin
      pix_p3_q <= '0;
      hit_p3_q <= 1'b0;
      vld_p3_q <= 1'b0;
    end else begin
      pix_p3_q <= pix_d;
      hit_p3_q <= hit_d;
      vld_p3_q <= vld_p2_q;
    end
  end

  assign bus.rom_addr      = rom_addr_p1_q;
  assign bus.pix_out       = pix_p3_q;
  assign bus.sprite_hit    = hit_p3_q;
  assign bus.pix_out_valid = vld_p3_q;

endmodule
